toy_mmio_responder: RTL and testbench

Data-port responder for the RISC_TOY core. It answers the core's synchronous-SRAM-style data transactions (DREQ, DRW, DADDR, DWDATA, DRDATA) inside one eight-word MMIO window, in place of a data RAM bank. Behind the window sit three resources: an 8-deep TX FIFO drained by a valid/ready consumer (e.g. the custom IP), a one-entry RX mailbox filled by a valid/ready producer, and a 32-bit compare timer with an interrupt.

---
 rtl/toy_mmio_responder.sv | 192 +++++++++++++++++++
 tb/tb_toy_mmio_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/toy_mmio_responder.sv
// MMIO responder for the RISC_TOY data port: an eight-word window exposing a TX FIFO,
// an RX mailbox and a 32-bit compare timer with interrupt.
module toy_mmio_responder #(
  parameter logic [26:0] BASE  = 27'h0,
  parameter int          DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DREQ,
  input  logic [1:0]  DRW,
  input  logic [29:0] DADDR,
  input  logic [31:0] DWDATA,
  output logic [31:0] DRDATA,
  output logic        TX_VALID,
  output logic [31:0] TX_DATA,
  input  logic        TX_READY,
  input  logic        RX_VALID,
  input  logic [31:0] RX_DATA,
  output logic        RX_READY,
  output logic        IRQ
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0] fifo_q [DEPTH];
  logic [31:0] fifo_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic        tx_ovf_q, tx_ovf_d, tmatch_q, tmatch_d;
  logic        rx_full_q, rx_full_d, ten_q, ten_d, ie_q, ie_d, irq_q, irq_d;
  logic [31:0] mbox_q, mbox_d, timer_q, timer_d, tcmp_q, tcmp_d, drdata_q, drdata_d;

  logic        hit_s, wr_s, rd_s, tx_full_s, tx_empty_s, pop_s, push_req_s, push_ok_s;
  logic        txclr_s, load_s, match_s, timer_wr_s;
  logic [2:0]  off_s;
  logic [31:0] status_s, rd_val_s;

  always_comb begin
    hit_s      = ~DREQ & (DADDR[29:3] == BASE);
    off_s      = DADDR[2:0];
    wr_s       = hit_s & ~DRW[0];
    rd_s       = hit_s & DRW[0];
    tx_empty_s = (count_q == CW'(0));
    tx_full_s  = (count_q == CW'(DEPTH));
    pop_s      = ~tx_empty_s & TX_READY;
    push_req_s = wr_s & (off_s == 3'd2);
    txclr_s    = wr_s & (off_s == 3'd0) & DWDATA[1];
    push_ok_s  = push_req_s & (~tx_full_s | pop_s);
    load_s     = RX_VALID & ~rx_full_q;
    timer_wr_s = wr_s & (off_s == 3'd4);
    match_s    = ten_q & ~timer_wr_s & (timer_q == tcmp_q);
    status_s   = {16'd0, 8'(count_q), 2'b00, tmatch_q, 1'b0, tx_ovf_q,
                  rx_full_q, tx_full_s, tx_empty_s};

    case (off_s)
      3'd0:    rd_val_s = {29'd0, ie_q, 1'b0, ten_q};
      3'd1:    rd_val_s = status_s;
      3'd3:    rd_val_s = mbox_q;
      3'd4:    rd_val_s = timer_q;
      3'd5:    rd_val_s = tcmp_q;
      default: rd_val_s = 32'd0;
    endcase

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // TXCLR beats any same-cycle push or pop, and the lost push is not an overflow.
    if (txclr_s) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        fifo_d[wr_ptr_q] = DWDATA;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_ok_s) - CW'(pop_s);
    end

    tx_ovf_d = tx_ovf_q;
    tmatch_d = tmatch_q;
    if (wr_s && off_s == 3'd1) begin
      tx_ovf_d = tx_ovf_q & ~DWDATA[3];
      tmatch_d = tmatch_q & ~DWDATA[5];
    end else begin
      tx_ovf_d = tx_ovf_q;
      tmatch_d = tmatch_q;
    end
    if (push_req_s && tx_full_s && !pop_s && !txclr_s) begin
      tx_ovf_d = 1'b1;
    end else begin
      tx_ovf_d = tx_ovf_d;
    end
    if (match_s) begin
      tmatch_d = 1'b1;
    end else begin
      tmatch_d = tmatch_d;
    end

    ten_d = ten_q;
    ie_d  = ie_q;
    if (wr_s && off_s == 3'd0) begin
      ten_d = DWDATA[0];
      ie_d  = DWDATA[2];
    end else begin
      ten_d = ten_q;
      ie_d  = ie_q;
    end

    if (wr_s && off_s == 3'd5) begin
      tcmp_d = DWDATA;
    end else begin
      tcmp_d = tcmp_q;
    end

    if (timer_wr_s) begin
      timer_d = DWDATA;
    end else if (match_s) begin
      timer_d = 32'd0;
    end else if (ten_q) begin
      timer_d = timer_q + 32'd1;
    end else begin
      timer_d = timer_q;
    end

    mbox_d    = mbox_q;
    rx_full_d = rx_full_q;
    if (load_s) begin
      mbox_d    = RX_DATA;
      rx_full_d = 1'b1;
    end else if (rd_s && off_s == 3'd3) begin
      rx_full_d = 1'b0;
    end else begin
      rx_full_d = rx_full_q;
    end

    if (rd_s) begin
      drdata_d = rd_val_s;
    end else begin
      drdata_d = drdata_q;
    end
    irq_d = ie_q & (tmatch_q | rx_full_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 32'd0;
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      tx_ovf_q  <= 1'b0;
      tmatch_q  <= 1'b0;
      rx_full_q <= 1'b0;
      ten_q     <= 1'b0;
      ie_q      <= 1'b0;
      irq_q     <= 1'b0;
      mbox_q    <= 32'd0;
      timer_q   <= 32'd0;
      tcmp_q    <= 32'hFFFF_FFFF;
      drdata_q  <= 32'd0;
    end else begin
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_ovf_q  <= tx_ovf_d;
      tmatch_q  <= tmatch_d;
      rx_full_q <= rx_full_d;
      ten_q     <= ten_d;
      ie_q      <= ie_d;
      irq_q     <= irq_d;
      mbox_q    <= mbox_d;
      timer_q   <= timer_d;
      tcmp_q    <= tcmp_d;
      drdata_q  <= drdata_d;
    end
  end

  assign DRDATA   = drdata_q;
  assign TX_VALID = (count_q != CW'(0));
  assign TX_DATA  = fifo_q[rd_ptr_q];
  assign RX_READY = ~rx_full_q;
  assign IRQ      = irq_q;
endmodule

// File: tb/tb_toy_mmio_responder.sv
// Directed bench for toy_mmio_responder: bus transactions with hand-computed expectations.
module tb_toy_mmio_responder;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        DREQ = 1'b1;
  logic [1:0]  DRW = 2'b01;
  logic [29:0] DADDR = 30'd0;
  logic [31:0] DWDATA = 32'd0;
  logic [31:0] DRDATA;
  logic        TX_VALID;
  logic [31:0] TX_DATA;
  logic        TX_READY = 1'b0;
  logic        RX_VALID = 1'b0;
  logic [31:0] RX_DATA = 32'd0;
  logic        RX_READY;
  logic        IRQ;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] rd_v;

  toy_mmio_responder dut (
    .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
    .DRDATA(DRDATA), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
    .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_READY(RX_READY), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
    DREQ = 1'b0; DRW = 2'b00; DADDR = a; DWDATA = d;
    tick();
    DREQ = 1'b1; DRW = 2'b01;
  endtask

  task automatic bus_read(input logic [29:0] a, output logic [31:0] d);
    DREQ = 1'b0; DRW = 2'b01; DADDR = a;
    tick();
    DREQ = 1'b1;
    d = DRDATA;
  endtask

  initial begin
    tick(); tick();
    RST = 1'b0;
    chk("rst_drdata", DRDATA, 32'd0);
    chk("rst_txvalid", {31'd0, TX_VALID}, 32'd0);
    chk("rst_rxready", {31'd0, RX_READY}, 32'd1);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    bus_read(30'd1, rd_v);
    chk("rst_status", rd_v, 32'h0000_0001);
    bus_read(30'd5, rd_v);
    chk("rst_tcmp", rd_v, 32'hFFFF_FFFF);

    // Overflow: nine pushes into an 8-deep FIFO with no consumer.
    for (int i = 1; i <= 9; i++) bus_write(30'd2, 32'(i));
    bus_read(30'd1, rd_v);
    chk("ovf_status", rd_v, 32'h0000_080A);
    bus_read(30'd2, rd_v);
    chk("txdata_read0", rd_v, 32'd0);
    TX_READY = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", TX_DATA, 32'(i));
      chk("drain_valid", {31'd0, TX_VALID}, 32'd1);
      tick();
    end
    TX_READY = 1'b0;
    chk("drained_valid", {31'd0, TX_VALID}, 32'd0);
    bus_write(30'd1, 32'h0000_0008);
    bus_read(30'd1, rd_v);
    chk("ovf_w1c", rd_v, 32'h0000_0001);

    // Push into a full FIFO while popping, then TXCLR against a pop.
    for (int i = 0; i < 8; i++) bus_write(30'd2, 32'hA0 + 32'(i));
    bus_read(30'd1, rd_v);
    chk("full_status", rd_v, 32'h0000_0802);
    TX_READY = 1'b1;
    bus_write(30'd2, 32'd10);
    TX_READY = 1'b0;
    bus_read(30'd1, rd_v);
    chk("full_pushpop", rd_v, 32'h0000_0802);
    chk("full_head", TX_DATA, 32'hA1);
    TX_READY = 1'b1;
    bus_write(30'd0, 32'd2);
    TX_READY = 1'b0;
    chk("clr_valid", {31'd0, TX_VALID}, 32'd0);
    bus_read(30'd1, rd_v);
    chk("clr_status", rd_v, 32'h0000_0001);
    bus_read(30'd0, rd_v);
    chk("ctrl_txclr_rd0", rd_v, 32'd0);

    // RX mailbox.
    RX_DATA = 32'hCAFE_F00D; RX_VALID = 1'b1;
    chk("rx_ready_pre", {31'd0, RX_READY}, 32'd1);
    tick();
    chk("rx_ready_low", {31'd0, RX_READY}, 32'd0);
    RX_DATA = 32'h1234_5678;
    bus_read(30'd1, rd_v);
    chk("rx_status", rd_v, 32'h0000_0005);
    bus_read(30'd3, rd_v);
    chk("rx_data1", rd_v, 32'hCAFE_F00D);
    chk("rx_ready_back", {31'd0, RX_READY}, 32'd1);
    tick();
    chk("rx_ready_reload", {31'd0, RX_READY}, 32'd0);
    RX_VALID = 1'b0;
    bus_read(30'd3, rd_v);
    chk("rx_data2", rd_v, 32'h1234_5678);
    chk("rx_ready_end", {31'd0, RX_READY}, 32'd1);

    // Timer compare and interrupt.
    bus_write(30'd5, 32'd3);
    bus_write(30'd0, 32'd5);
    DREQ = 1'b0; DRW = 2'b01; DADDR = 30'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("timer_seq", DRDATA, (i == 4) ? 32'd0 : 32'(i));
      if (i == 3) chk("irq_before", {31'd0, IRQ}, 32'd0);
    end
    DREQ = 1'b1;
    chk("irq_set", {31'd0, IRQ}, 32'd1);
    bus_write(30'd0, 32'd4);
    bus_write(30'd1, 32'h0000_0020);
    chk("irq_hold", {31'd0, IRQ}, 32'd1);
    tick();
    chk("irq_drop", {31'd0, IRQ}, 32'd0);
    bus_read(30'd4, rd_v);
    chk("timer_held", rd_v, 32'd2);
    bus_read(30'd1, rd_v);
    chk("tmatch_clr", rd_v, 32'h0000_0001);

    // Requests outside the window.
    bus_write(30'h0000_000D, 32'h55);
    bus_write(30'h0000_0008, 32'h1);
    bus_write(30'h0000_000A, 32'h77);
    bus_read(30'h0000_000C, rd_v);
    chk("miss_drdata", rd_v, 32'h0000_0001);
    chk("miss_txvalid", {31'd0, TX_VALID}, 32'd0);
    bus_read(30'd5, rd_v);
    chk("miss_tcmp", rd_v, 32'd3);
    bus_read(30'd0, rd_v);
    chk("miss_ctrl", rd_v, 32'd4);

    // Reset mid-operation.
    bus_write(30'd2, 32'hDEAD_BEEF);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst2_txvalid", {31'd0, TX_VALID}, 32'd0);
    chk("rst2_drdata", DRDATA, 32'd0);
    bus_read(30'd5, rd_v);
    chk("rst2_tcmp", rd_v, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
